// File: rtl/core_irq_pkg.sv
// ---------------------------------------------------------------------------
// core_irq_pkg
// Shared types and constants for the multi-channel IRQ moderator.
//   svc_state_t : shared service FSM states (one-hot)
//   mod_state_t : per-channel moderation FSM states (one-hot)
//   MSI_W       : width of the MSI vector driven to the CFG interface
//   ch_idx_w()  : width of a channel index, never less than 1 bit
// ---------------------------------------------------------------------------
package core_irq_pkg;

  localparam int MSI_W = 8;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_REQ       = 5'b00010,
    S_CHK       = 5'b00100,
    S_IRQ       = 5'b01000,
    S_WAIT_TBUF = 5'b10000
  } svc_state_t;

  typedef enum logic [2:0] {
    M_IDLE    = 3'b001,
    M_WAIT_EN = 3'b010,
    M_HOLD    = 3'b100
  } mod_state_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_irq_mod_ch.sv
// ---------------------------------------------------------------------------
// core_irq_mod_ch
// One interrupt channel: the pending flag plus its moderation FSM
// (wait for the host re-arm, then a programmable holdoff).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   send_irq   request pulse
//   irq_dis    while high, requests are ignored
//   irq_en     re-arm pulse from the host
//   irq_thr    holdoff threshold, sampled on re-arm
//   done       MSI handshake for this channel completes this cycle
//   pend       registered pending flag
//   eligible   channel may be picked by the arbiter
// ---------------------------------------------------------------------------
module core_irq_mod_ch
  import core_irq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_irq,
  input  logic             irq_dis,
  input  logic             irq_en,
  input  logic [CNT_W-1:0] irq_thr,
  input  logic             done,
  output logic             pend,
  output logic             eligible
);

  logic             pend_reg;
  mod_state_t       mod_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] thr_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg  <= 1'b0;
      mod_reg   <= M_IDLE;
      cnt_reg   <= '0;
      thr_q_reg <= '0;
    end else begin
      // A new request arriving on the handshake cycle must not be lost,
      // so set has priority over clear.
      if (send_irq && !irq_dis) begin
        pend_reg <= 1'b1;
      end else if (done) begin
        pend_reg <= 1'b0;
      end

      if (done) begin
        mod_reg <= M_WAIT_EN;
      end else begin
        case (mod_reg)
          M_IDLE: begin
            mod_reg <= M_IDLE;
          end
          M_WAIT_EN: begin
            if (irq_en) begin
              mod_reg   <= M_HOLD;
              cnt_reg   <= '0;
              thr_q_reg <= irq_thr;
            end
          end
          M_HOLD: begin
            // Exit on the cycle the count reaches the threshold: thr+1 cycles.
            if (cnt_reg == thr_q_reg) begin
              mod_reg <= M_IDLE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            mod_reg <= M_IDLE;
          end
        endcase
      end
    end
  end

  assign pend     = pend_reg;
  assign eligible = pend_reg && (mod_reg == M_IDLE);

endmodule

// File: rtl/core_irq_moderator.sv
// ---------------------------------------------------------------------------
// core_irq_moderator
// Latches interrupt requests from NUM_CH channels, arbitrates round-robin,
// acquires the TX endpoint (req_ep/my_trn/drv_ep) and issues one MSI per
// grant over the cfg_interrupt handshake with the channel number as vector.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   irq_en[NUM_CH]        per-channel re-arm pulse
//   irq_dis[NUM_CH]       per-channel request mask (level)
//   irq_thr               per-channel holdoff threshold, CNT_W bits each
//   send_irq[NUM_CH]      per-channel request pulse
//   cfg_interrupt_n       MSI request, active-low (registered)
//   cfg_interrupt_rdy_n   MSI acknowledge, active-low
//   cfg_interrupt_di      MSI vector = served channel (registered)
//   trn_tbuf_av           TX buffer availability
//   my_trn                endpoint grant
//   req_ep, drv_ep        endpoint request / ownership (registered)
//   irq_pending[NUM_CH]   pending flags for status readback
// ---------------------------------------------------------------------------
module core_irq_moderator
  import core_irq_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int TBUF_BIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       irq_en,
  input  logic [NUM_CH-1:0]       irq_dis,
  input  logic [NUM_CH*CNT_W-1:0] irq_thr,
  input  logic [NUM_CH-1:0]       send_irq,
  output logic                    cfg_interrupt_n,
  input  logic                    cfg_interrupt_rdy_n,
  output logic [MSI_W-1:0]        cfg_interrupt_di,
  input  logic [3:0]              trn_tbuf_av,
  input  logic                    my_trn,
  output logic                    req_ep,
  output logic                    drv_ep,
  output logic [NUM_CH-1:0]       irq_pending
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  svc_state_t        state_reg;
  logic [CH_W-1:0]   sel_reg;
  logic [CH_W-1:0]   rr_reg;
  logic              req_ep_reg;
  logic              drv_ep_reg;
  logic              cfg_n_reg;
  logic [MSI_W-1:0]  di_reg;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] done_vec;
  logic [NUM_CH-1:0] pend_vec;
  logic              irq_ack;
  logic              tbuf_ok;

  logic              pick_valid;
  logic [CH_W-1:0]   pick_next;
  logic [CH_W:0]     arb_idx;

  assign tbuf_ok = trn_tbuf_av[TBUF_BIT];
  assign irq_ack = (state_reg == S_IRQ) && !cfg_interrupt_rdy_n;

  // Per-channel pend/moderation slices; done fires only for the latched sel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign done_vec[gi] = irq_ack && (sel_reg == CH_W'(gi));

      core_irq_mod_ch #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .send_irq (send_irq[gi]),
        .irq_dis  (irq_dis[gi]),
        .irq_en   (irq_en[gi]),
        .irq_thr  (irq_thr[gi*CNT_W +: CNT_W]),
        .done     (done_vec[gi]),
        .pend     (pend_vec[gi]),
        .eligible (elig[gi])
      );
    end
  endgenerate

  // Round-robin: scan from the channel after the last served one, wrapping.
  // The sum rr+1+k is below 2*NUM_CH, so one conditional subtract wraps it.
  always_comb begin
    pick_valid = 1'b0;
    pick_next  = '0;
    arb_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = {1'b0, rr_reg} + (CH_W+1)'(k + 1);
      if (arb_idx >= (CH_W+1)'(NUM_CH)) begin
        arb_idx = arb_idx - (CH_W+1)'(NUM_CH);
      end
      if (!pick_valid && elig[arb_idx[CH_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_next  = arb_idx[CH_W-1:0];
      end
    end
  end

  // Service FSM. sel is latched once in S_IDLE and held until the handshake,
  // so masking or new requests never redirect an MSI already under way.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      sel_reg    <= '0;
      rr_reg     <= CH_W'(NUM_CH - 1);
      req_ep_reg <= 1'b0;
      drv_ep_reg <= 1'b0;
      cfg_n_reg  <= 1'b1;
      di_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            sel_reg    <= pick_next;
            req_ep_reg <= 1'b1;
            state_reg  <= S_REQ;
          end
        end
        S_REQ: begin
          if (my_trn) begin
            req_ep_reg <= 1'b0;
            drv_ep_reg <= 1'b1;
            state_reg  <= S_CHK;
          end
        end
        S_CHK: begin
          if (tbuf_ok) begin
            cfg_n_reg <= 1'b0;
            di_reg    <= MSI_W'(sel_reg);
            state_reg <= S_IRQ;
          end else begin
            // Release the endpoint while the buffer drains; re-request later.
            drv_ep_reg <= 1'b0;
            state_reg  <= S_WAIT_TBUF;
          end
        end
        S_IRQ: begin
          if (!cfg_interrupt_rdy_n) begin
            cfg_n_reg  <= 1'b1;
            drv_ep_reg <= 1'b0;
            rr_reg     <= sel_reg;
            state_reg  <= S_IDLE;
          end
        end
        S_WAIT_TBUF: begin
          if (tbuf_ok) begin
            req_ep_reg <= 1'b1;
            state_reg  <= S_REQ;
          end
        end
        default: begin
          req_ep_reg <= 1'b0;
          drv_ep_reg <= 1'b0;
          cfg_n_reg  <= 1'b1;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_interrupt_n  = cfg_n_reg;
  assign cfg_interrupt_di = di_reg;
  assign req_ep           = req_ep_reg;
  assign drv_ep           = drv_ep_reg;
  assign irq_pending      = pend_vec;

endmodule

// File: doc/core_irq_moderator.md
# core_irq_moderator

Multi-channel successor of the single-channel PCIe IRQ generator. It latches interrupt requests from NUM_CH DMA/host-control channels and arbitrates among them round-robin. It obtains the TX endpoint through the req_ep/my_trn/drv_ep arbitration protocol and issues one MSI per grant via the cfg_interrupt handshake, carrying the channel number as the MSI vector. Each channel has its own interrupt-moderation state: a re-arm wait on irq_en, then a programmable holdoff counter. It sits between the host-control register block and the endpoint's CFG interrupt interface.

## Interface
- NUM_CH, 2: number of interrupt channels, 1..8.
- CNT_W, 32: width of each holdoff threshold/counter.
- TBUF_BIT, 1: index of the trn_tbuf_av bit that must be set before an MSI is issued.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- irq_en  in  NUM_CH  per-channel re-arm pulse from the host (driver finished servicing).
- irq_dis  in  NUM_CH  per-channel level; while high, new send_irq requests are ignored.
- irq_thr  in  NUM_CH*CNT_W  per-channel holdoff threshold; channel i occupies bits [i*CNT_W +: CNT_W].
- send_irq  in  NUM_CH  per-channel request pulse.
- cfg_interrupt_n  out  1  MSI request to the CFG interface, active-low.
- cfg_interrupt_rdy_n  in  1  CFG acknowledge, active-low.
- cfg_interrupt_di  out  8  MSI vector = index of the channel being served, zero-extended.
- trn_tbuf_av  in  4  TX buffer availability.
- my_trn  in  1  endpoint grant.
- req_ep  out  1  endpoint request.
- drv_ep  out  1  endpoint ownership held.
- irq_pending  out  NUM_CH  latched pending flags, for status readback.

## Operation
- pend[i]:
  - Set when send_irq[i] && !irq_dis[i].
  - Cleared on the cycle the CFG handshake for channel i completes.
  - If a set and a clear hit the same cycle, set wins.
  - Repeated requests while already pending are coalesced into the single pending flag.
- Per-channel moderation FSM, mod[i]:
  - M_IDLE: the channel is eligible for arbitration when pend[i]=1.
  - M_WAIT_EN: entered when channel i's handshake completes. On irq_en[i], go to M_HOLD, clear cnt[i] to 0 and latch thr_q[i] <= irq_thr[i].
  - M_HOLD: cnt[i] increments each cycle. When cnt[i]==thr_q[i], go to M_IDLE. The holdoff therefore lasts thr_q+1 cycles, and thr=0 gives 1 cycle.
  - irq_en[i] in any state other than M_WAIT_EN is ignored.
- Shared service FSM:
  - S_IDLE: if any channel is eligible, pick the next one round-robin starting after the last served channel (initial pointer = NUM_CH-1, so ch0 wins first). Latch it into sel, set req_ep=1, go to S_REQ.
  - S_REQ: on my_trn, req_ep=0, drv_ep=1, go to S_CHK.
  - S_CHK:
    - If trn_tbuf_av[TBUF_BIT]: cfg_interrupt_n=0, cfg_interrupt_di=sel, go to S_IRQ.
    - Otherwise: drv_ep=0, go to S_WAIT_TBUF.
  - S_IRQ: on !cfg_interrupt_rdy_n: cfg_interrupt_n=1, drv_ep=0, clear pend[sel], mod[sel] goes to M_WAIT_EN, RR pointer = sel, go to S_IDLE.
  - S_WAIT_TBUF: on trn_tbuf_av[TBUF_BIT], req_ep=1, go to S_REQ. sel is kept.
- Once latched, sel is not re-arbitrated. Raising irq_dis[sel] mid-service does not abort the MSI.
- Illegal state encodings return to S_IDLE / M_IDLE.

## Timing
- Reset values:
  - cfg_interrupt_n=1, req_ep=0, drv_ep=0, cfg_interrupt_di=0, irq_pending=0.
  - All mod=M_IDLE, all cnt=0, RR pointer = NUM_CH-1.
- All outputs are registered.
- Latencies:
  - send_irq at cycle N gives irq_pending at N+1 and req_ep at N+2 (if the service FSM is idle).
  - my_trn at N gives drv_ep at N+1 and cfg_interrupt_n low at N+2 if the buffer is available.
  - Handshake at N gives cfg_interrupt_n=1 and drv_ep=0 at N+1.
  - Earliest next req_ep is N+2.
- cfg_interrupt_n is held low, and cfg_interrupt_di held stable, until rdy is seen.
- drv_ep never overlaps req_ep.
- rst mid-transaction returns everything to the reset values on the next edge; pending requests are lost.

## Structure
- Package core_irq_pkg holds:
  - Service and moderation state enums (one-hot encoding, as in the existing IRQ block).
  - MSI vector width constant (8).
- One sub-module, core_irq_mod_ch: the per-channel pend/moderation FSM and counter, instantiated NUM_CH times with a generate loop.
- Arbiter and service FSM live in the top level.

## Test plan
- Single channel, thr=3: send_irq[0], grant after 2 cycles, rdy after 1 cycle.
  - Expect exactly one MSI with di=0.
  - irq_en[0] at T; a new send_irq at T+1 yields req_ep no earlier than T+5.
- NUM_CH=4, all send_irq in the same cycle, immediate grant/rdy, irq_en pulses right after each MSI.
  - Expect MSI vectors in order 0,1,2,3; then a new request on all channels gives 0 again.
- trn_tbuf_av[1]=0 at S_CHK.
  - Expect drv_ep to drop and req_ep to stay 0 until the bit rises, then req_ep=1.
  - MSI is issued with the original sel.
- send_irq[1] on the same cycle as the ch1 handshake.
  - Expect irq_pending[1] to remain 1, but no ch1 MSI until irq_en[1] plus the holdoff.
- irq_dis[2]=1 with send_irq[2] pulses: expect no req_ep and irq_pending[2]=0.
- Assert rst while in S_IRQ: next cycle cfg_interrupt_n=1, drv_ep=0, irq_pending=0.
